// File: rtl/pico_bus_pkg.sv
// Shared definitions for the PicoRV32 native-bus N-slave multiplexer.
//   state_t          : handshake FSM states (IDLE, ACCESS, DONE)
//   DATA_W           : bus data/address width
//   ERR_CNT_W        : width of the saturating error counter
//   DEFAULT_RDATA_C  : read data returned on unmapped or timed-out accesses
package pico_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DATA_W    = 32;
    localparam int ERR_CNT_W = 16;

    localparam logic [DATA_W-1:0] DEFAULT_RDATA_C = 32'hDEAD_BEEF;

endpackage

// File: rtl/pico_bus_decode.sv
// Combinational address decoder for pico_bus_mux_n.
//   addr : look-ahead address to decode
//   hit  : 1 when any slave window matches (addr & MASK) == BASE
//   sel  : index of the matching slave; the lowest index wins on overlap
module pico_bus_decode
    import pico_bus_pkg::*;
#(
    parameter int                        NSLAVES    = 3,
    parameter int                        SEL_W      = 2,
    parameter logic [NSLAVES*DATA_W-1:0] SLAVE_BASE = '0,
    parameter logic [NSLAVES*DATA_W-1:0] SLAVE_MASK = '0
) (
    input  logic [DATA_W-1:0] addr,
    output logic              hit,
    output logic [SEL_W-1:0]  sel
);

    // Scan from the highest index down so a lower-index match overwrites.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[DATA_W*i +: DATA_W]) == SLAVE_BASE[DATA_W*i +: DATA_W]) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/pico_bus_mux_n.sv
// N-slave address-decoding multiplexer between the PicoRV32 native memory
// bus and TCM / register slaves.
//   clock, reset   : system clock, synchronous active-high reset
//   i_la_addr      : CPU look-ahead address, decoded while IDLE
//   i_valid        : CPU mem_valid
//   o_ready        : CPU mem_ready (slave ready routed combinationally)
//   o_rdata        : CPU mem_rdata
//   o_slave_valid  : one-hot per-slave valid
//   i_slave_ready  : per-slave ready
//   i_slave_rdata  : slave i read data at [32*i +: 32]
//   o_err          : pulses with o_ready on an unmapped or timed-out access
//   o_err_count    : saturating count of o_err pulses
// Optional feature: define PICO_BUS_MUX_TIMEOUT_EN to abandon a slave that
// does not answer within TIMEOUT_CYCLES cycles of ACCESS.
module pico_bus_mux_n
    import pico_bus_pkg::*;
#(
    parameter int                        NSLAVES        = 3,
    parameter logic [NSLAVES*DATA_W-1:0] SLAVE_BASE     = {32'h0100_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NSLAVES*DATA_W-1:0] SLAVE_MASK     = {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000},
    parameter logic [DATA_W-1:0]         DEFAULT_RDATA  = DEFAULT_RDATA_C,
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           i_la_addr,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [NSLAVES-1:0]          o_slave_valid,
    input  logic [NSLAVES-1:0]          i_slave_ready,
    input  logic [NSLAVES*DATA_W-1:0]   i_slave_rdata,
    output logic                        o_err,
    output logic [ERR_CNT_W-1:0]        o_err_count
);

    localparam int SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic               hit_q;
    logic               unmap_pend_q;

    logic               dec_hit;
    logic [SEL_W-1:0]   dec_sel;

    pico_bus_decode #(
        .NSLAVES    (NSLAVES),
        .SEL_W      (SEL_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr (i_la_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    logic               sel_ready;
    logic [DATA_W-1:0]  sel_rdata;
    logic               in_access;
    logic               to_fire;
    logic               ok_fire;
    logic               err_fire;

    assign sel_ready = i_slave_ready[sel_q];
    assign sel_rdata = i_slave_rdata[DATA_W*sel_q +: DATA_W];
    assign in_access = (state == ACCESS) && i_valid;

`ifdef PICO_BUS_MUX_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [TO_W-1:0] wait_q;
    // A ready in the timeout cycle still completes normally.
    assign to_fire = hit_q && !sel_ready && (wait_q == TO_W'(TIMEOUT_CYCLES));
`else
    assign to_fire = 1'b0;
`endif

    assign ok_fire  = in_access && hit_q && sel_ready;
    // Unmapped accesses answer one cycle after ACCESS entry.
    assign err_fire = in_access && ((!hit_q && unmap_pend_q) || to_fire);

    assign o_ready = ok_fire || err_fire;
    assign o_err   = err_fire;
    assign o_rdata = ((state == ACCESS) && hit_q && !to_fire) ? sel_rdata : DEFAULT_RDATA;

    always_comb begin
        o_slave_valid = '0;
        if (in_access && hit_q && !to_fire)
            o_slave_valid[sel_q] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            sel_q        <= '0;
            hit_q        <= 1'b0;
            unmap_pend_q <= 1'b0;
            o_err_count  <= '0;
`ifdef PICO_BUS_MUX_TIMEOUT_EN
            wait_q       <= '0;
`endif
        end else begin
            if (o_err)
                o_err_count <= sat_inc(o_err_count);

            case (state)
                IDLE: begin
                    sel_q        <= dec_sel;
                    hit_q        <= dec_hit;
                    unmap_pend_q <= 1'b0;
`ifdef PICO_BUS_MUX_TIMEOUT_EN
                    wait_q       <= '0;
`endif
                    if (i_valid)
                        state <= ACCESS;
                end
                ACCESS: begin
                    if (!i_valid) begin
                        state        <= IDLE;
                        unmap_pend_q <= 1'b0;
                    end else if (o_ready) begin
                        state        <= DONE;
                        unmap_pend_q <= 1'b0;
                    end else begin
                        unmap_pend_q <= !hit_q;
`ifdef PICO_BUS_MUX_TIMEOUT_EN
                        wait_q       <= wait_q + 1'b1;
`endif
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pico_bus_mux_n.sv
module tb_pico_bus_mux_n;

    localparam int NS = 4;
    localparam int TO = 4;
    localparam logic [31:0] DEF = 32'hDEAD_BEEF;

    // Slave 3 overlaps slaves 0 and 1 so the lowest-index rule is exercised.
    localparam logic [NS*32-1:0] P_BASE = {32'h0000_0000, 32'h0100_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] P_MASK = {32'hFF00_0000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic [31:0] m_base [NS] = '{32'h0000_0000, 32'h0001_0000, 32'h0100_0000, 32'h0000_0000};
    logic [31:0] m_mask [NS] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFF00_0000};

    logic              clock = 1'b0;
    logic              reset;
    logic [31:0]       la_addr;
    logic              valid;
    logic              o_ready;
    logic [31:0]       o_rdata;
    logic [NS-1:0]     o_slave_valid;
    logic [NS-1:0]     s_ready;
    logic [NS*32-1:0]  s_rdata;
    logic              o_err;
    logic [15:0]       o_err_count;

    pico_bus_mux_n #(
        .NSLAVES        (NS),
        .SLAVE_BASE     (P_BASE),
        .SLAVE_MASK     (P_MASK),
        .DEFAULT_RDATA  (DEF),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_la_addr     (la_addr),
        .i_valid       (valid),
        .o_ready       (o_ready),
        .o_rdata       (o_rdata),
        .o_slave_valid (o_slave_valid),
        .i_slave_ready (s_ready),
        .i_slave_rdata (s_rdata),
        .o_err         (o_err),
        .o_err_count   (o_err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic        exp_ready;
    logic [NS-1:0] exp_sv;
    int          checks;
    int          failures;
    bit          prev_done;

    `ifdef PICO_BUS_MUX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    `else
    localparam bit TO_EN = 1'b0;
    `endif

    // Reference decode: first window (lowest index) that matches, else -1.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & m_mask[i]) == m_base[i]) return i;
        return -1;
    endfunction

    // Monitor: per-cycle handshake expectations plus scoreboard on o_ready.
    initial begin
        exp_t e;
        int   cnt_model;
        cnt_model = 0;
        forever begin
            @(negedge clock);
            checks++;
            if (o_ready !== exp_ready) begin
                failures++;
                $display("FAIL ready t=%0t got=%b want=%b", $time, o_ready, exp_ready);
            end
            checks++;
            if (o_slave_valid !== exp_sv) begin
                failures++;
                $display("FAIL slave_valid t=%0t got=%b want=%b", $time, o_slave_valid, exp_sv);
            end
            checks++;
            if (o_err_count !== 16'(cnt_model)) begin
                failures++;
                $display("FAIL err_count t=%0t got=%0d want=%0d", $time, o_err_count, cnt_model);
            end
            if (o_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ready t=%0t got=1 want=0 (no access outstanding)", $time);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (o_rdata !== e.rdata) begin
                        failures++;
                        $display("FAIL rdata t=%0t got=%h want=%h", $time, o_rdata, e.rdata);
                    end
                    checks++;
                    if (o_err !== e.err) begin
                        failures++;
                        $display("FAIL err t=%0t got=%b want=%b", $time, o_err, e.err);
                    end
                    if (e.err && cnt_model < 65535) cnt_model++;
                end
            end else begin
                checks++;
                if (o_err !== 1'b0) begin
                    failures++;
                    $display("FAIL err_idle t=%0t got=%b want=0", $time, o_err);
                end
            end
            if (reset) cnt_model = 0;
        end
    end

    // One CPU access. Called #1 after a posedge; returns #1 after a posedge.
    task automatic run_access(input logic [31:0] addr, input int d, input int abort_at,
                              input bit b2b, input bit by_reset);
        int          s;
        int          comp;
        bit          err_exp;
        exp_t        e;
        logic [NS-1:0] onehot;
        s = ref_decode(addr);
        onehot = (s >= 0) ? (NS'(1) << s) : '0;
        if (!prev_done) b2b = 1'b0;
        la_addr   = addr;
        s_ready   = '0;
        exp_sv    = '0;
        exp_ready = 1'b0;
        for (int k = 0; k < NS; k++) s_rdata[32*k +: 32] = $urandom;
        if (!b2b) begin
            valid = 1'b0;
            @(posedge clock); #1;
        end
        valid = 1'b1;
        if (b2b) begin
            @(posedge clock); #1;
        end
        if (s < 0) begin
            comp = 1;
            err_exp = 1'b1;
        end else if (TO_EN && d > TO) begin
            comp = TO;
            err_exp = 1'b1;
        end else begin
            comp = d;
            err_exp = 1'b0;
        end
        e.err   = err_exp;
        e.rdata = err_exp ? DEF : s_rdata[32*s +: 32];
        if (abort_at < 0 || abort_at > comp) sb.push_back(e);
        @(posedge clock); #1;
        for (int n = 0; n <= comp; n++) begin
            if (n == abort_at) begin
                if (by_reset) begin
                    reset  = 1'b1;
                    exp_sv = onehot;
                end else begin
                    valid  = 1'b0;
                    exp_sv = '0;
                end
                exp_ready = 1'b0;
                @(posedge clock); #1;
                reset     = 1'b0;
                valid     = 1'b0;
                exp_sv    = '0;
                exp_ready = 1'b0;
                prev_done = 1'b0;
                return;
            end
            if (s >= 0 && n == d) s_ready[s] = 1'b1;
            exp_sv    = (s >= 0 && !(err_exp && n == comp)) ? onehot : '0;
            exp_ready = (n == comp);
            @(posedge clock); #1;
        end
        s_ready   = '0;
        exp_sv    = '0;
        exp_ready = 1'b0;
        prev_done = 1'b1;
    endtask

    initial begin
        int        cls;
        int        d;
        int        s;
        int        ab;
        logic [31:0] a;
        checks    = 0;
        failures  = 0;
        prev_done = 1'b0;
        reset     = 1'b1;
        la_addr   = '0;
        valid     = 1'b0;
        s_ready   = '0;
        s_rdata   = '0;
        exp_ready = 1'b0;
        exp_sv    = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        run_access(32'h0000_0010, 0, -1, 0, 0);
        run_access(32'h0001_0004, 3, -1, 0, 0);
        run_access(32'h0200_0000, 0, -1, 0, 0);
        run_access(32'h0005_0000, 1, -1, 0, 0);
        run_access(32'h0000_0020, 2, -1, 1, 0);
        run_access(32'h0100_0004, 4, -1, 0, 0);
        run_access(32'h0100_0008, 9, -1, 0, 0);
        run_access(32'h0001_0008, 1, -1, 1, 0);
        run_access(32'h0300_0000, 0, -1, 1, 0);
        run_access(32'h0001_0000, 5,  2, 0, 0);
        run_access(32'h0400_0000, 0,  1, 0, 0);
        run_access(32'h0001_000C, 0, -1, 0, 0);
        run_access(32'h0001_0010, 8,  1, 0, 1);
        run_access(32'h0000_0040, 1, -1, 0, 0);

        for (int t = 0; t < 3000; t++) begin
            cls = $urandom_range(0, 4);
            case (cls)
                0:       a = {16'h0000, 16'($urandom)};
                1:       a = {16'h0001, 16'($urandom)};
                2:       a = {20'h01000, 12'($urandom)};
                3:       a = {8'h00, 24'($urandom)};
                default: a = $urandom;
            endcase
            d  = $urandom_range(0, 6);
            s  = ref_decode(a);
            ab = -1;
            if ($urandom_range(0, 15) == 0) begin
                if (s < 0) ab = $urandom_range(0, 1);
                else if (d > 0) ab = $urandom_range(0, ((TO_EN && d > TO) ? TO : d) - 1);
            end
            run_access(a, d, ab, ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0) && (ab >= 0) && (s >= 0));
        end

        valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL outstanding got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
